// File: rtl/pulse_duration_capture_pkg.sv
// rtl/pulse_duration_capture_pkg.sv - shared widths, depths and FSM states for pulse duration capture
package pulse_duration_capture_pkg;

    // Same values the test data generator uses on the playback side
    localparam int PULSE_DURATION_SIZE = 15;
    localparam int PULSE_BUF_DEPTH     = 16;
    localparam int PULSE_BUF_IDX_W     = 4;
    localparam int PDC_W               = PULSE_DURATION_SIZE + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_EDGE,
        ST_MEASURE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pulse_duration_capture_if.sv
// rtl/pulse_duration_capture_if.sv - control, pulse input and read-back bundle of the capture block
interface pulse_duration_capture_if #(
    parameter int W = pulse_duration_capture_pkg::PDC_W
) ();
    logic         arm;
    logic         sig_in;
    logic         next;
    logic [W-1:0] out;
    logic         done;
    logic         busy;
    logic         first_level;
    logic         saturated;

    modport master (
        output arm, sig_in, next,
        input  out, done, busy, first_level, saturated
    );

    modport slave (
        input  arm, sig_in, next,
        output out, done, busy, first_level, saturated
    );
endinterface

// File: rtl/pulse_duration_capture_sync_edge_detect.sv
// rtl/pulse_duration_capture_sync_edge_detect.sv - 2-flop synchronizer with delayed copy for edge detection
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_edge
);
    logic r_meta;
    logic r_sync;
    logic r_dly;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_dly  <= 1'b0;
        end else begin
            r_meta <= i_sig;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    // Every edge goes through the same three flops, so all edges share one latency
    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_dly;
    assign o_fall  = ~r_sync & r_dly;
    assign o_edge  = r_sync ^ r_dly;
endmodule

// File: rtl/pulse_duration_capture.sv
// rtl/pulse_duration_capture.sv - measures high/low segment widths of sig_in into a 16-entry buffer
module pulse_duration_capture
    import pulse_duration_capture_pkg::*;
#(
    parameter int W     = PDC_W,
    parameter int DEPTH = PULSE_BUF_DEPTH,
    parameter int IDX_W = PULSE_BUF_IDX_W
) (
    input  logic                    clk,
    input  logic                    rst,
    pulse_duration_capture_if.slave bus
);
    localparam logic [W-1:0]     CNT_MAX  = {W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic             w_level;
    logic             w_rise;
    logic             w_fall;
    logic             w_edge;
    logic             w_wr;

    state_t           r_state;
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic [W-1:0]     r_cnt;
    logic             r_cnt_clamped;
    logic             r_done;
    logic             r_busy;
    logic             r_first_level;
    logic             r_saturated;
    logic [W-1:0]     r_buf [DEPTH];

    sync_edge_detect u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_sig   (bus.sig_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall),
        .o_edge  (w_edge)
    );

    // A restart takes priority over an edge landing in the same cycle
    assign w_wr = (r_state == ST_MEASURE) && w_edge && !bus.arm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_wr_idx      <= '0;
            r_cnt         <= '0;
            r_cnt_clamped <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_first_level <= 1'b0;
            r_saturated   <= 1'b0;
        end else if (bus.arm) begin
            r_state     <= ST_WAIT_EDGE;
            r_wr_idx    <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b1;
            r_saturated <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_EDGE: begin
                    if (w_rise || w_fall) begin
                        r_cnt         <= W'(1);
                        r_cnt_clamped <= 1'b0;
                        r_first_level <= w_level;
                        r_state       <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (w_edge) begin
                        r_cnt         <= W'(1);
                        r_cnt_clamped <= 1'b0;
                        r_wr_idx      <= r_wr_idx + 1'b1;
                        r_saturated   <= r_saturated | r_cnt_clamped;
                        if (r_wr_idx == LAST_IDX) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_cnt == CNT_MAX) begin
                        // Remember that the segment outlived the counter range
                        r_cnt_clamped <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read index wraps on its own; only reset moves it back to entry 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_idx <= '0;
        end else if (bus.next) begin
            r_rd_idx <= r_rd_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[r_wr_idx] <= r_cnt;
        end
    end

    assign bus.out         = r_buf[r_rd_idx];
    assign bus.done        = r_done;
    assign bus.busy        = r_busy;
    assign bus.first_level = r_first_level;
    assign bus.saturated   = r_saturated;
endmodule

// File: tb/tb_pulse_duration_capture.sv
// tb/tb_pulse_duration_capture.sv - scoreboard bench for pulse_duration_capture
module tb_pulse_duration_capture;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pulse_duration_capture_if #(.W(16)) u_if ();
    pulse_duration_capture_if #(.W(8))  u_if8 ();

    pulse_duration_capture #(.W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    pulse_duration_capture #(.W(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (u_if8.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    int q_exp[$];
    int m_rd = 0;
    int m_buf[16];
    int m_w[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic seg(input logic lvl, input int n);
        u_if.sig_in = lvl;
        cyc(n);
    endtask

    task automatic arm_pulse();
        u_if.arm = 1'b1;
        cyc(1);
        u_if.arm = 1'b0;
    endtask

    task automatic next_pulse();
        u_if.next = 1'b1;
        cyc(1);
        u_if.next = 1'b0;
        m_rd = (m_rd + 1) % 16;
    endtask

    task automatic wait_done();
        int k = 0;
        while (u_if.done !== 1'b1 && k < 40) begin
            cyc(1);
            k++;
        end
        chk("done", u_if.done, 1);
    endtask

    // Drives the 16 widths in m_w starting with level first_lvl, then a trailing edge
    task automatic capture(input logic first_lvl);
        logic lvl = first_lvl;
        for (int i = 0; i < 16; i++) begin
            seg(lvl, m_w[i]);
            q_exp.push_back(m_w[i]);
            m_buf[i] = m_w[i];
            lvl = ~lvl;
        end
        chk("busy_pre", u_if.busy, 1);
        chk("done_pre", u_if.done, 0);
        u_if.sig_in = lvl;
        wait_done();
        chk("busy_post", u_if.busy, 0);
    endtask

    task automatic read_back(input string tag, input int n);
        repeat (m_rd) q_exp.push_back(q_exp.pop_front());
        for (int i = 0; i < n; i++) begin
            if (q_exp.size() == 0) begin
                chk({tag, "_underflow"}, 1, 0);
            end else begin
                chk(tag, u_if.out, q_exp.pop_front());
            end
            next_pulse();
        end
    endtask

    initial begin
        u_if.arm = 1'b0;  u_if.sig_in = 1'b0;  u_if.next = 1'b0;
        u_if8.arm = 1'b0; u_if8.sig_in = 1'b0; u_if8.next = 1'b0;
        @(posedge clk);
        #1;

        // reset held with sig_in toggling, then released
        for (int i = 0; i < 3; i++) seg(~u_if.sig_in, 1);
        chk("rst_busy", u_if.busy, 0);
        chk("rst_done", u_if.done, 0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) seg(~u_if.sig_in, 2);
        chk("idle_busy", u_if.busy, 0);
        chk("idle_done", u_if.done, 0);
        chk("idle_first_level", u_if.first_level, 0);
        chk("idle_saturated", u_if.saturated, 0);

        // basic capture with the generator pattern
        m_w = '{65, 75, 85, 95, 105, 115, 4454, 125, 140, 140, 140, 140, 10, 10, 10, 10};
        seg(1'b0, 5);
        arm_pulse();
        capture(1'b1);
        chk("basic_first_level", u_if.first_level, 1);
        chk("basic_saturated", u_if.saturated, 0);
        read_back("basic_rd", 16);
        q_exp.push_back(m_w[0]);
        read_back("basic_wrap", 1);

        // minimum width: one cycle per segment
        for (int i = 0; i < 16; i++) m_w[i] = 1;
        cyc(5);
        arm_pulse();
        capture(1'b0);
        chk("min_first_level", u_if.first_level, 0);
        chk("min_saturated", u_if.saturated, 0);
        read_back("min_rd", 16);

        // restart mid-capture after five entries
        cyc(5);
        arm_pulse();
        for (int i = 0; i < 6; i++) seg(~u_if.sig_in, 7);
        chk("rearm_busy_mid", u_if.busy, 1);
        arm_pulse();
        for (int i = 0; i < 16; i++) m_w[i] = 20 + i;
        capture(~u_if.sig_in);
        read_back("rearm_rd", 16);

        // asynchronous reset in the middle of a measurement
        cyc(5);
        arm_pulse();
        seg(~u_if.sig_in, 10);
        chk("ares_busy_before", u_if.busy, 1);
        #2 rst = 1'b0;
        #1 chk("ares_busy_now", u_if.busy, 0);
        cyc(2);
        rst = 1'b1;
        m_rd = 0;
        for (int i = 0; i < 4; i++) seg(~u_if.sig_in, 5);
        chk("ares_busy_after", u_if.busy, 0);
        chk("ares_done_after", u_if.done, 0);
        chk("ares_no_write", u_if.out, m_buf[0]);

        // saturation on the narrow-word instance
        u_if8.arm = 1'b1;
        cyc(1);
        u_if8.arm = 1'b0;
        u_if8.sig_in = 1'b1;
        q_exp.push_back(255);
        cyc(300);
        u_if8.sig_in = 1'b0;
        q_exp.push_back(40);
        cyc(40);
        u_if8.sig_in = 1'b1;
        cyc(6);
        chk("sat_flag", u_if8.saturated, 1);
        chk("sat_busy", u_if8.busy, 1);
        chk("sat_entry0", u_if8.out, q_exp.pop_front());
        u_if8.next = 1'b1;
        cyc(1);
        u_if8.next = 1'b0;
        chk("sat_entry1", u_if8.out, q_exp.pop_front());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
